// File: rtl/data_memory_bw.sv
// Byte/halfword/word data memory for the MEM stage. Registered loads, written-word tracking, misalignment flag.
// Optional macro DMEM_BOUNDS_CHECK_EN adds a RangeErr output and drops out-of-range accesses.
module data_memory_bw #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MemWre,
  input  logic                  MemRead,
  input  logic [1:0]            AccessSize,
  input  logic                  LoadUnsigned,
  input  logic [ADDR_WIDTH-1:0] DataAddress,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  DataValid,
  output logic                  AlignErr
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic                  RangeErr
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]            mem_q [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] written_q, written_d;
  logic [31:0]            data_out_q, data_out_d;
  logic                   valid_q, valid_d;
  logic                   align_q, align_d;
  logic                   range_q, range_d;

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             is_byte, is_half, misalign, out_of_range, req, ok;
  logic             do_wr, do_rd;
  logic [1:0]       sh;
  logic [3:0]       size_mask, lane_en;
  logic [31:0]      base_word, wdata, merged, rshift;

  assign idx     = DataAddress[IDX_W+1:2];
  assign off     = DataAddress[1:0];
  assign is_byte = (AccessSize == 2'b00);
  assign is_half = (AccessSize == 2'b01);
  assign misalign = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
  assign req      = MemWre || MemRead;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign out_of_range = (64'(DataAddress) >= 64'(DEPTH_WORDS) * 64'd4);
`else
  assign out_of_range = 1'b0;
`endif

  assign ok    = !misalign && !out_of_range;
  assign do_wr = MemWre && ok;
  assign do_rd = MemRead && !MemWre && ok;

  // Byte-lane shift of the addressed sub-word within the 32-bit word (lane 0 = bits [7:0]).
  always_comb begin
    sh        = 2'd0;
    size_mask = 4'b1111;
    if (is_byte) begin
      size_mask = 4'b0001;
      sh        = BIG_ENDIAN ? 2'(2'd3 - off) : off;
    end else if (is_half) begin
      size_mask = 4'b0011;
      sh        = BIG_ENDIAN ? 2'(2'd2 - off) : off;
    end
  end

  assign lane_en   = size_mask << sh;
  assign wdata     = DataIn << {sh, 3'b000};
  assign base_word = written_q[idx] ? mem_q[idx] : 32'd0;
  assign rshift    = base_word >> {sh, 3'b000};

  // Unwritten words merge against zero, so untouched bytes always read back as 0.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign merged[8*k +: 8] = lane_en[k] ? wdata[8*k +: 8] : base_word[8*k +: 8];
  end

  always_comb begin
    written_d  = written_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    align_d    = req && misalign;
    range_d    = req && !misalign && out_of_range;
    if (do_wr) written_d[idx] = 1'b1;
    if (do_rd) begin
      valid_d = 1'b1;
      if (is_byte)
        data_out_d = LoadUnsigned ? {24'd0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      else if (is_half)
        data_out_d = LoadUnsigned ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      else
        data_out_d = rshift;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      written_q  <= '0;
      data_out_q <= 32'd0;
      valid_q    <= 1'b0;
      align_q    <= 1'b0;
      range_q    <= 1'b0;
    end else begin
      written_q  <= written_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      align_q    <= align_d;
      range_q    <= range_d;
    end
  end

  // Storage is deliberately not reset; the written bitmap masks stale contents.
  always_ff @(posedge Clk) begin
    if (Reset && do_wr) mem_q[idx] <= merged;
  end

  assign DataOut   = data_out_q;
  assign DataValid = valid_q;
  assign AlignErr  = align_q;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign RangeErr  = range_q;
`else
  logic unused_range;
  assign unused_range = range_q;
`endif

endmodule

// File: doc/data_memory_bw.md
Name: data_memory_bw

Overview:
- Parametrised successor to the single-cycle word data memory in the pipeline CPU's MEM stage.
- Adds byte/halfword/word access with sign or zero extension for loads.
- Adds a registered (1-cycle) read with a valid strobe, misalignment detection, and per-word written-tracking so never-written words read as zero after reset.
- Sits between the EX/MEM pipeline register and the MEM/WB register.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, at least 4.
- ADDR_WIDTH, 32, width of DataAddress (byte address).
- BIG_ENDIAN, 1, 1 = byte 0 of a word is DataIn[31:24]; 0 = byte 0 is DataIn[7:0].

Ports:
- Clk  input  1  system clock, rising edge active.
- Reset  input  1  asynchronous, active-low reset.
- MemWre  input  1  store request, sampled on rising Clk.
- MemRead  input  1  load request, sampled on rising Clk.
- AccessSize  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- LoadUnsigned  input  1  1 = zero-extend sub-word loads; 0 = sign-extend.
- DataAddress  input  ADDR_WIDTH  byte address.
- DataIn  input  32  store data; the sub-word is taken from the low bits (DataIn[7:0] or DataIn[15:0]).
- DataOut  output  32  registered load result.
- DataValid  output  1  1-cycle pulse: DataOut updated by a load.
- AlignErr  output  1  1-cycle pulse: the previous access was misaligned.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous, active-low.
- While Reset = 0:
  - DataOut = 0, DataValid = 0, AlignErr = 0.
  - The written-bitmap (DEPTH_WORDS bits) is cleared.
  - All requests are ignored.
  - The storage array itself is not reset.
- Word index = DataAddress[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS*4.
- Misaligned access: halfword with addr[0] = 1, or word with addr[1:0] != 00.
  - No write is performed and no read data is returned.
  - AlignErr = 1 on the next cycle, DataValid = 0, DataOut holds its previous value.
- Store (MemWre = 1, aligned): at the rising edge, only the addressed byte lanes are written, honouring BIG_ENDIAN; other bytes of the word are unchanged. The word's written-bit is set.
  - A sub-word store to a word whose written-bit is clear first zero-fills the other bytes of that word. Unwritten bytes therefore always read 0.
- Load (MemRead = 1, MemWre = 0, aligned):
  - One cycle latency: DataOut and DataValid = 1 are registered on the rising edge that samples the request.
  - Byte and halfword results are extended to 32 bits per LoadUnsigned.
  - A word whose written-bit is clear returns 0.
- MemWre and MemRead both 1: the store wins and the load is dropped (DataValid = 0). Decided behaviour; it never occurs in the pipeline.
- Back-to-back store then load to the same address on consecutive cycles: the load returns the newly stored data. No forwarding is needed because the array is updated at the earlier edge.
- No request: DataValid = 0, AlignErr = 0, DataOut holds.
- Reset asserted mid-operation: any pending result is discarded and outputs go to their reset values immediately.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN.
- When defined:
  - Any access with DataAddress >= DEPTH_WORDS*4 is out of range.
  - No write is performed and no load data is returned.
  - An extra output RangeErr (1 bit, reset 0) pulses 1 on the next cycle.
  - If an access is both misaligned and out of range, AlignErr takes priority and RangeErr stays 0.
- When undefined: the RangeErr port does not exist and addresses wrap as described above.

Test Plan:
- Word store then load: store word 0x00000001 to addr 8, then load word from addr 8 (signed) -> next cycle DataOut = 0x00000001, DataValid = 1.
- Never-written word: after reset, load word from addr 4 -> DataOut = 0x00000000, DataValid = 1.
- Byte store and extension (BIG_ENDIAN = 1):
  - Store byte 0x85 to addr 0x11, then load word from 0x10 -> 0x00850000.
  - Load byte from 0x11, signed -> 0xFFFFFF85; unsigned -> 0x00000085.
- Halfword lane write: store word 0x11223344 to 0x20, store half 0xBEEF to 0x22 -> load word from 0x20 = 0x1122BEEF; load half from 0x22, signed -> 0xFFFFBEEF.
- Misalignment: store word 0xDEADBEEF to 0x21 -> AlignErr pulses 1, DataValid = 0; a following load word from 0x20 still returns 0x1122BEEF.
- Async reset: assert Reset = 0 mid-clock after a load issues -> DataOut = 0 and DataValid = 0 immediately; after release, load word from 0x20 -> 0x00000000.
